loop_nest_sequencer: RTL and testbench

//  Sequences an NDepth-deep loop nest for the accelerator datapath. Accepts a loop-size config via

---
 rtl/loop_nest_sequencer_pkg.sv | 24 ++
 rtl/loop_nest_sequencer_stage.sv | 61 ++++++
 rtl/loop_nest_sequencer.sv | 117 +++++++++++
 tb/tb_loop_nest_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loop_nest_sequencer_pkg.sv
// Shared definitions for the loop nest sequencer.
//   lp_ctl_t     : {dval, inc, reset} step command mirrored to slave loop counters
//   ST_*         : FSM state encodings (IDLE -> RUN -> DONE -> IDLE)
//   DONE_PULSE_W : width in cycles of the o_done pulse (DONE state dwell)
//   CTL_*        : the three o_ctl command values the sequencer ever drives
package loop_nest_sequencer_pkg;

   typedef struct packed {
      logic dval;
      logic inc;
      logic reset;
   } lp_ctl_t;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int DONE_PULSE_W = 1;

   localparam lp_ctl_t CTL_NONE = 3'b000;
   localparam lp_ctl_t CTL_LOAD = 3'b101;
   localparam lp_ctl_t CTL_STEP = 3'b110;

endpackage

// File: rtl/loop_nest_sequencer_stage.sv
// One level of the loop nest: holds the trip-count register and the
// 1-based index register for that level.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (size = idx = 1)
//   load      : latch size (masked to W bits, 0 -> 1) and reset idx to 1
//   size      : raw trip count, only the low W bits are meaningful
//   adv       : advance idx by one
//   wrap      : reload idx to 1 (takes priority over adv)
//   idx       : current index, zero-extended to IdxMaxDW bits
//   at_end    : idx == size
module loop_idx_stage #(
   parameter int W        = 3,
   parameter int IdxMaxDW = 11
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [IdxMaxDW-1:0] size,
   input  logic                adv,
   input  logic                wrap,
   output logic [IdxMaxDW-1:0] idx,
   output logic                at_end
);

   logic [W-1:0] size_q;
   logic [W-1:0] idx_q;
   logic [W-1:0] size_m;

   // A zero trip count is treated as one so every level runs at least once.
   always_comb begin
      size_m = size[W-1:0];
      if (size_m == '0) size_m = W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         size_q <= W'(1);
         idx_q  <= W'(1);
      end else if (load) begin
         size_q <= size_m;
         idx_q  <= W'(1);
      end else if (wrap) begin
         idx_q  <= W'(1);
      end else if (adv) begin
         // idx <= size < 2^W, and adv is only applied below size, so no overflow.
         idx_q  <= idx_q + W'(1);
      end
   end

   assign at_end = (idx_q == size_q);
   assign idx    = IdxMaxDW'(idx_q);

   // Bits above W are deliberately ignored.
   generate
      if (W < IdxMaxDW) begin : g_hi
         logic unused_hi;
         assign unused_hi = ^size[IdxMaxDW-1:W];
      end
   endgenerate

endmodule

// File: rtl/loop_nest_sequencer.sv
// Sequences an NDepth-deep loop nest (level 0 innermost). A config of per-level
// trip counts is accepted in IDLE; one index tuple per beat is then emitted on a
// valid/ready stream in lexicographic order (level NDepth-1 most significant),
// followed by a one-cycle o_done pulse. Every index step is mirrored on o_ctl.
// Ports:
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_cfg_valid   : config offered        o_cfg_ready : high only in IDLE
//   i_loopSize    : per-level trip counts, sampled on the config handshake
//   i_abort       : terminate current nest, back to IDLE next cycle
//   o_valid/i_ready : tuple stream handshake
//   o_idx         : current 1-based indices
//   o_loopEnd     : per-level idx == size, qualified by o_valid
//   o_last        : final beat of the nest
//   o_done        : one-cycle pulse after the final beat is accepted
//   o_busy        : state != IDLE
//   o_ctl         : {dval, inc, reset} command for slave counters
//   o_state       : FSM state, for observation
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high. o_valid never depends on i_ready, and once high it stays high with a
// stable payload until the transfer or an abort.
module loop_nest_sequencer
   import loop_nest_sequencer_pkg::*;
#(
   parameter int NDepth            = 3,
   parameter int IdxDW [NDepth]    = '{3, 5, 3},
   parameter int IdxMaxDW          = 11
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_cfg_valid,
   output logic                           o_cfg_ready,
   input  logic [NDepth-1:0][IdxMaxDW-1:0] i_loopSize,
   input  logic                           i_abort,
   output logic                           o_valid,
   input  logic                           i_ready,
   output logic [NDepth-1:0][IdxMaxDW-1:0] o_idx,
   output logic [NDepth-1:0]              o_loopEnd,
   output logic                           o_last,
   output logic                           o_done,
   output logic                           o_busy,
   output lp_ctl_t                        o_ctl,
   output logic [1:0]                     o_state
);

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [NDepth-1:0] at_end;
   logic [NDepth:0]   end_chain;
   logic              all_end;
   logic              cfg_fire;
   logic              beat_fire;
   logic              step;

   // end_chain[i] = levels 0..i-1 all at end; level i advances on end_chain[i]
   // and reloads on end_chain[i+1].
   assign end_chain[0] = 1'b1;
   assign all_end      = end_chain[NDepth];

   // Abort beats the config handshake; an aborted beat still transfers but
   // the indices are not stepped since the nest is discarded.
   assign cfg_fire  = (state == ST_IDLE) && i_cfg_valid && !i_abort;
   assign beat_fire = o_valid && i_ready;
   assign step      = beat_fire && !all_end && !i_abort;

   genvar gi;
   generate
      for (gi = 0; gi < NDepth; gi++) begin : g_lvl
         assign end_chain[gi+1] = end_chain[gi] & at_end[gi];

         loop_idx_stage #(
            .W        (IdxDW[gi]),
            .IdxMaxDW (IdxMaxDW)
         ) u_stage (
            .clk    (i_clk),
            .rst    (i_rst),
            .load   (cfg_fire),
            .size   (i_loopSize[gi]),
            .adv    (step && end_chain[gi]),
            .wrap   (step && end_chain[gi+1]),
            .idx    (o_idx[gi]),
            .at_end (at_end[gi])
         );
      end
   endgenerate

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (cfg_fire) state_nxt = ST_RUN;
         ST_RUN:  if (beat_fire && all_end) state_nxt = ST_DONE;
         // DONE lasts DONE_PULSE_W (= 1) cycle.
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      if (i_abort) state_nxt = ST_IDLE;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      o_ctl = CTL_NONE;
      if (cfg_fire)  o_ctl = CTL_LOAD;
      else if (step) o_ctl = CTL_STEP;
   end

   assign o_cfg_ready = (state == ST_IDLE);
   assign o_valid     = (state == ST_RUN);
   assign o_loopEnd   = o_valid ? at_end : '0;
   assign o_last      = o_valid && all_end;
   assign o_done      = (state == ST_DONE);
   assign o_busy      = (state != ST_IDLE);
   assign o_state     = state;

endmodule

// File: tb/tb_loop_nest_sequencer.sv
module tb_loop_nest_sequencer;
   import loop_nest_sequencer_pkg::*;

   localparam int ND = 3;
   localparam int MW = 11;
   localparam int DW [ND] = '{3, 5, 3};

   logic                   i_clk;
   logic                   i_rst;
   logic                   i_cfg_valid;
   logic                   o_cfg_ready;
   logic [ND-1:0][MW-1:0]  i_loopSize;
   logic                   i_abort;
   logic                   o_valid;
   logic                   i_ready;
   logic [ND-1:0][MW-1:0]  o_idx;
   logic [ND-1:0]          o_loopEnd;
   logic                   o_last;
   logic                   o_done;
   logic                   o_busy;
   lp_ctl_t                o_ctl;
   logic [1:0]             o_state;

   // {last, idx2, idx1, idx0}
   logic [3*MW:0] exp_q[$];
   int            cur_sz [ND];
   int            n_tests = 0;
   int            n_fail  = 0;
   int            beats_seen = 0;
   int            inc_cnt = 0;
   int            rst_cnt = 0;
   int            done_cnt = 0;
   logic          stall_pend = 1'b0;
   logic [3*MW-1:0] held_idx;

   loop_nest_sequencer dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_cfg_valid (i_cfg_valid),
      .o_cfg_ready (o_cfg_ready),
      .i_loopSize  (i_loopSize),
      .i_abort     (i_abort),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_idx       (o_idx),
      .o_loopEnd   (o_loopEnd),
      .o_last      (o_last),
      .o_done      (o_done),
      .o_busy      (o_busy),
      .o_ctl       (o_ctl),
      .o_state     (o_state)
   );

   // ---------------- clock ----------------
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic int eff_size(input int s, input int dw);
      int m;
      m = s & ((1 << dw) - 1);
      return (m == 0) ? 1 : m;
   endfunction

   function automatic logic [2:0] exp_end(input logic [3*MW:0] e);
      logic [2:0] r;
      r[0] = (int'(e[MW-1:0])      == cur_sz[0]);
      r[1] = (int'(e[2*MW-1:MW])   == cur_sz[1]);
      r[2] = (int'(e[3*MW-1:2*MW]) == cur_sz[2]);
      return r;
   endfunction

   task automatic check_rst_outputs(input string tag);
      logic [3*MW-1:0] ones;
      ones = {11'd1, 11'd1, 11'd1};
      check({tag, "_cfg_ready"}, o_cfg_ready, 1);
      check({tag, "_valid"},     o_valid, 0);
      check({tag, "_last"},      o_last, 0);
      check({tag, "_done"},      o_done, 0);
      check({tag, "_busy"},      o_busy, 0);
      check({tag, "_loop_end"},  o_loopEnd, 0);
      check({tag, "_ctl"},       o_ctl, 0);
      check({tag, "_idx"},       o_idx, ones);
      check({tag, "_state"},     o_state, ST_IDLE);
   endtask

   // ---------------- scoreboard / monitor ----------------
   always @(negedge i_clk) begin
      logic [3*MW:0] e;
      if (i_rst) begin
         stall_pend = 1'b0;
      end else begin
         if (o_ctl.inc)   inc_cnt++;
         if (o_ctl.reset) rst_cnt++;
         if (o_done)      done_cnt++;
         if (stall_pend) begin
            check("stall_valid", o_valid, 1);
            check("stall_idx", o_idx, held_idx);
         end
         stall_pend = o_valid && !i_ready && !i_abort;
         held_idx   = o_idx;
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("idx", o_idx, e[3*MW-1:0]);
               check("last", o_last, e[3*MW]);
               check("loop_end", o_loopEnd, exp_end(e));
               beats_seen++;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_nest(input int s0, input int s1, input int s2);
      logic [3*MW:0] ent;
      cur_sz[0] = eff_size(s0, DW[0]);
      cur_sz[1] = eff_size(s1, DW[1]);
      cur_sz[2] = eff_size(s2, DW[2]);
      for (int c = 1; c <= cur_sz[2]; c++)
         for (int b = 1; b <= cur_sz[1]; b++)
            for (int a = 1; a <= cur_sz[0]; a++) begin
               ent = {(a == cur_sz[0] && b == cur_sz[1] && c == cur_sz[2]),
                      11'(c), 11'(b), 11'(a)};
               exp_q.push_back(ent);
            end
   endtask

   // Called just after a rising edge; returns just after the accept edge.
   task automatic send_cfg(input int s0, input int s1, input int s2);
      int k;
      k = 0;
      while (!o_cfg_ready && k < 100) begin
         @(posedge i_clk); #1;
         k++;
      end
      if (!o_cfg_ready) check("cfg_ready_timeout", 1, 0);
      push_nest(s0, s1, s2);
      i_loopSize  = {11'(s2), 11'(s1), 11'(s0)};
      i_cfg_valid = 1'b1;
      #1;
      check("cfg_ctl", o_ctl, CTL_LOAD);
      @(posedge i_clk); #1;
      i_cfg_valid = 1'b0;
      check("latency_valid", o_valid, 1);
      check("cfg_busy", o_busy, 1);
   endtask

   task automatic run_to_done(input bit rnd, input int budget, input int exp_beats);
      int  b0;
      bit  seen;
      b0   = beats_seen;
      seen = 0;
      for (int k = 0; k < budget && !seen; k++) begin
         i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge i_clk); #1;
         if (o_done) seen = 1;
      end
      if (!seen) begin
         check("done_timeout", 1, 0);
      end else begin
         check("done_valid", o_valid, 0);
         check("done_cfg_ready", o_cfg_ready, 0);
         check("done_busy", o_busy, 1);
         check("beats", beats_seen - b0, exp_beats);
         check("queue_empty", exp_q.size(), 0);
         @(posedge i_clk); #1;
         check("post_done", o_done, 0);
         check("post_cfg_ready", o_cfg_ready, 1);
         check("post_busy", o_busy, 0);
      end
      i_ready = 1'b1;
   endtask

   task automatic wait_beats(input int b0, input int n);
      int k;
      k = 0;
      while (beats_seen - b0 < n && k < 200) begin
         @(posedge i_clk); #1;
         k++;
      end
      if (beats_seen - b0 < n) check("beat_wait_timeout", 1, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int b0;
      int i0;
      int r0;
      int d0;
      i_rst       = 1'b1;
      i_cfg_valid = 1'b0;
      i_loopSize  = '0;
      i_abort     = 1'b0;
      i_ready     = 1'b0;
      #3;
      check_rst_outputs("rst_held");
      repeat (2) @(posedge i_clk);
      #1 i_rst = 1'b0;
      check_rst_outputs("rst_rel");

      // 1: sizes {2,3,2}, always ready
      i_ready = 1'b1;
      send_cfg(2, 3, 2);
      run_to_done(0, 100, 12);

      // 2: same config, random backpressure
      i0 = inc_cnt;
      r0 = rst_cnt;
      send_cfg(2, 3, 2);
      run_to_done(1, 400, 12);
      check("t2_inc_count", inc_cnt - i0, 11);
      check("t2_reset_count", rst_cnt - r0, 1);

      // 3: single-beat nest
      send_cfg(1, 1, 1);
      check("t3_loop_end", o_loopEnd, 3'b111);
      check("t3_last", o_last, 1);
      run_to_done(0, 20, 1);

      // 4: zero size and masked upper bits
      send_cfg(0, 5, 'hF9);
      run_to_done(0, 50, 5);

      // 5: full-range nest, then abort on beat 4 with its handshake
      send_cfg(7, 31, 7);
      run_to_done(1'b0, 2000, 1519);
      send_cfg(7, 31, 7);
      b0 = beats_seen;
      wait_beats(b0, 3);
      i_abort = 1'b1;
      @(posedge i_clk); #1;
      i_abort = 1'b0;
      check("abort_beats", beats_seen - b0, 4);
      check("abort_valid", o_valid, 0);
      check("abort_busy", o_busy, 0);
      check("abort_cfg_ready", o_cfg_ready, 1);
      check("abort_ctl", o_ctl, 0);
      exp_q.delete();
      d0 = done_cnt;
      repeat (3) @(posedge i_clk);
      #1;
      check("abort_no_done", done_cnt - d0, 0);
      send_cfg(2, 3, 2);
      run_to_done(0, 100, 12);

      // abort has priority over a config offer in IDLE
      i_cfg_valid = 1'b1;
      i_abort     = 1'b1;
      i_loopSize  = {11'd2, 11'd2, 11'd2};
      #1;
      check("abort_idle_ctl", o_ctl, 0);
      @(posedge i_clk); #1;
      i_cfg_valid = 1'b0;
      i_abort     = 1'b0;
      check("abort_idle_valid", o_valid, 0);
      check("abort_idle_busy", o_busy, 0);

      // 6: asynchronous reset mid-beat
      send_cfg(2, 3, 2);
      b0 = beats_seen;
      wait_beats(b0, 3);
      @(posedge i_clk); #2;
      i_rst = 1'b1;
      #1;
      check_rst_outputs("async_rst");
      exp_q.delete();
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge i_clk); #1;
         check("post_rst_valid", o_valid, 0);
         check("post_rst_cfg_ready", o_cfg_ready, 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
